i_cache_tag_ctrl: RTL and testbench

- Initiator and owner of the 64-entry I-cache tag RAM.
- Accepts fetch lookups from the IFU, reads the tag RAM, compares tags and reports hit or miss.
- On a miss, requests a line refill and writes the new valid tag after the refill completes.
- Performs the full-array invalidate sweep for fence.i.
- Sits between the IFU, the tag RAM and the I-cache refill engine.

---
 rtl/i_cache_pkg.sv | 36 +++
 rtl/i_cache_tag_ctrl_if.sv | 35 +++
 rtl/i_cache_tag_ram.sv | 25 ++
 rtl/i_cache_tag_ctrl.sv | 119 +++++++++++
 tb/tb_i_cache_tag_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i_cache_pkg.sv
// rtl/i_cache_pkg.sv - I-cache tag widths, entry layout, FSM encoding and address helpers
package i_cache_pkg;

  localparam int ADDR_W    = 64;
  localparam int IDX_W     = 6;
  localparam int OFF_W     = 3;
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int ENT_W     = TAG_W + 1;
  localparam int VALID_BIT = TAG_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_FILL   = 3'd3,
    S_FLUSH  = 3'd4
  } state_e;

  function automatic logic [IDX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W+IDX_W-1:OFF_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFF_W+IDX_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  // Entry layout: valid bit on top, tag below it.
  function automatic logic [ENT_W-1:0] make_entry(input logic valid, input logic [TAG_W-1:0] tag);
    return {valid, tag};
  endfunction

endpackage

// File: rtl/i_cache_tag_ctrl_if.sv
// rtl/i_cache_tag_ctrl_if.sv - IFU, refill engine and tag RAM signals of the tag controller
interface i_cache_tag_ctrl_if;
  import i_cache_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic              resp_valid_o;
  logic              resp_hit_o;
  logic              refill_req_o;
  logic [ADDR_W-1:0] refill_addr_o;
  logic              refill_done_i;
  logic              flush_i;
  logic              flush_done_o;
  logic [IDX_W-1:0]  tag_addr_o;
  logic [ENT_W-1:0]  tag_wdata_o;
  logic              tag_we_o;
  logic [TAG_W-1:0]  tag_rdata_i;
  logic              tag_valid_i;

  // Controller side.
  modport slave (
    input  req_valid_i, req_addr_i, refill_done_i, flush_i, tag_rdata_i, tag_valid_i,
    output req_ready_o, resp_valid_o, resp_hit_o, refill_req_o, refill_addr_o,
           flush_done_o, tag_addr_o, tag_wdata_o, tag_we_o
  );

  // Environment side: IFU, refill engine and tag RAM.
  modport master (
    output req_valid_i, req_addr_i, refill_done_i, flush_i, tag_rdata_i, tag_valid_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, refill_req_o, refill_addr_o,
           flush_done_o, tag_addr_o, tag_wdata_o, tag_we_o
  );

endinterface

// File: rtl/i_cache_tag_ram.sv
// rtl/i_cache_tag_ram.sv - 64-entry tag RAM, synchronous read with 1-cycle latency
module i_cache_tag_ram
  import i_cache_pkg::*;
(
  input  logic             clk,
  input  logic [IDX_W-1:0] i_addr,
  input  logic             i_we,
  input  logic [ENT_W-1:0] i_wdata,
  output logic [TAG_W-1:0] o_rdata,
  output logic             o_valid
);

  logic [ENT_W-1:0] r_mem [0:(1<<IDX_W)-1];
  logic [ENT_W-1:0] r_rd;

  // A write cycle performs no read, so the read register holds its old value.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    else      r_rd <= r_mem[i_addr];
  end

  assign o_rdata = r_rd[TAG_W-1:0];
  assign o_valid = r_rd[VALID_BIT];

endmodule

// File: rtl/i_cache_tag_ctrl.sv
// rtl/i_cache_tag_ctrl.sv - I-cache tag lookup/refill/flush controller; option ICACHE_TAG_RST_FLUSH_EN
module i_cache_tag_ctrl
  import i_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  i_cache_tag_ctrl_if.slave bus
);

`ifdef ICACHE_TAG_RST_FLUSH_EN
  // Reset release schedules a full sweep before the first lookup.
  localparam logic RST_PEND = 1'b1;
`else
  localparam logic RST_PEND = 1'b0;
`endif

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_flush_pend;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic              w_hit;
  logic              w_sweep_last;
  logic              w_flush_go;

  assign w_tag        = get_tag(r_addr);
  assign w_idx        = get_index(r_addr);
  assign w_hit        = bus.tag_valid_i & (bus.tag_rdata_i == w_tag);
  assign w_sweep_last = (r_cnt == {IDX_W{1'b1}});
  assign w_flush_go   = r_flush_pend | bus.flush_i;

  // Next state and all outputs; a flush always beats a simultaneous request.
  always_comb begin
    w_next            = r_state;
    bus.req_ready_o   = 1'b0;
    bus.resp_valid_o  = 1'b0;
    bus.resp_hit_o    = 1'b0;
    bus.refill_req_o  = 1'b0;
    bus.refill_addr_o = '0;
    bus.flush_done_o  = 1'b0;
    bus.tag_addr_o    = '0;
    bus.tag_wdata_o   = '0;
    bus.tag_we_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_flush_go) begin
          w_next = S_FLUSH;
        end else begin
          bus.req_ready_o = 1'b1;
          if (bus.req_valid_i) begin
            bus.tag_addr_o = get_index(bus.req_addr_i);
            w_next         = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          bus.resp_valid_o = 1'b1;
          bus.resp_hit_o   = 1'b1;
          w_next           = S_IDLE;
        end else begin
          w_next = S_MISS;
        end
      end
      S_MISS: begin
        bus.refill_req_o  = 1'b1;
        bus.refill_addr_o = line_addr(r_addr);
        if (bus.refill_done_i) w_next = S_FILL;
      end
      S_FILL: begin
        bus.tag_we_o     = 1'b1;
        bus.tag_addr_o   = w_idx;
        bus.tag_wdata_o  = make_entry(1'b1, w_tag);
        bus.resp_valid_o = 1'b1;
        w_next           = S_IDLE;
      end
      S_FLUSH: begin
        bus.tag_we_o   = 1'b1;
        bus.tag_addr_o = r_cnt;
        if (w_sweep_last) begin
          bus.flush_done_o = 1'b1;
          w_next           = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, latched request address and sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (w_flush_go)           r_cnt  <= '0;
        else if (bus.req_valid_i) r_addr <= bus.req_addr_i;
      end
      if (r_state == S_FLUSH) r_cnt <= r_cnt + IDX_W'(1);
    end
  end

  // Pending flush: pulses seen outside IDLE collapse into one sweep, cleared when a sweep ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_pend <= RST_PEND;
    end else if (r_state == S_FLUSH && w_sweep_last) begin
      r_flush_pend <= 1'b0;
    end else if (bus.flush_i && r_state != S_IDLE) begin
      r_flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i_cache_tag_ctrl.sv
// tb/tb_i_cache_tag_ctrl.sv - scoreboard bench for i_cache_tag_ctrl with i_cache_tag_ram
module tb_i_cache_tag_ctrl;
  import i_cache_pkg::*;

  localparam logic [1:0] EV_REFILL = 2'd0;
  localparam logic [1:0] EV_WRITE  = 2'd1;
  localparam logic [1:0] EV_RESP   = 2'd2;
  localparam logic [1:0] EV_FDONE  = 2'd3;

`ifdef ICACHE_TAG_RST_FLUSH_EN
  localparam logic [63:0] RST_READY = 64'd0;
`else
  localparam logic [63:0] RST_READY = 64'd1;
`endif

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = -100;
  int   ready_in_sweep = 0;
  logic prev_refill = 1'b0;
  ev_t  exp_q[$];

  i_cache_tag_ctrl_if bus();

  i_cache_tag_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  i_cache_tag_ram ram (
    .clk     (clk),
    .i_addr  (bus.tag_addr_o),
    .i_we    (bus.tag_we_o),
    .i_wdata (bus.tag_wdata_o),
    .o_rdata (bus.tag_rdata_i),
    .o_valid (bus.tag_valid_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [63:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [IDX_W-1:0] idx, input logic [ENT_W-1:0] entry);
    push(EV_WRITE, {2'b00, idx, entry});
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 64; i++) push_wr(6'(i), '0);
    push(EV_FDONE, 64'd0);
  endtask

  task automatic push_miss(input logic [63:0] raddr, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    push(EV_REFILL, raddr);
    push_wr(idx, {1'b1, tag});
    push(EV_RESP, 64'd0);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [63:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL unexpected_event kind %0d: got %0h, required no event", kind, data);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_kind_%0d", e.kind), 64'(kind), 64'(e.kind));
      check($sformatf("event_data_kind_%0d", e.kind), data, e.data);
    end
  endtask

  // Monitor: compares every DUT event against the scoreboard, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.refill_req_o && !prev_refill) observe(EV_REFILL, bus.refill_addr_o);
      if (bus.tag_we_o) begin
        observe(EV_WRITE, {2'b00, bus.tag_addr_o, bus.tag_wdata_o});
        if (bus.req_ready_o) ready_in_sweep = ready_in_sweep + 1;
      end
      if (bus.resp_valid_o) begin
        observe(EV_RESP, 64'(bus.resp_hit_o));
        if (bus.resp_hit_o) check("hit_cycles_from_accept", 64'(cyc - acc_cyc + 1), 64'd2);
      end
      if (bus.flush_done_o) observe(EV_FDONE, 64'd0);
      if (bus.req_valid_i && bus.req_ready_o) acc_cyc = cyc;
    end
    prev_refill = bus.refill_req_o;
  end

  task automatic do_req(input logic [63:0] addr, input bit with_flush);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    if (with_flush) begin
      bus.flush_i = 1'b1;
      @(negedge clk);
      check("flush_beats_req_ready", 64'(bus.req_ready_o), 64'd0);
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_refill();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.refill_req_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("refill_req_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_refill(input bit with_flush);
    wait_refill();
    @(posedge clk); #1;
    if (with_flush) begin
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
    end
    bus.refill_done_i = 1'b1;
    @(posedge clk); #1;
    bus.refill_done_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    check({"drain_", name}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i   = 1'b0;
    bus.req_addr_i    = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.refill_done_i = 1'b0;
    bus.flush_i       = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
`ifdef ICACHE_TAG_RST_FLUSH_EN
    push_sweep();
`endif
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'(bus.req_ready_o), RST_READY);
    check("reset_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("reset_refill_req", 64'(bus.refill_req_o), 64'd0);
    check("reset_tag_we", 64'(bus.tag_we_o), 64'd0);
    check("reset_flush_done", 64'(bus.flush_done_o), 64'd0);

`ifndef ICACHE_TAG_RST_FLUSH_EN
    push_sweep();
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
`endif
    wait_drain("init_sweep");

    push_miss(64'h8000_0048, 6'd9, 55'h40_0000);
    do_req(64'h8000_0048, 1'b0);
    do_refill(1'b0);
    wait_drain("cold_miss");

    push(EV_RESP, 64'd1);
    do_req(64'h8000_004C, 1'b0);
    wait_drain("hit");

    push_miss(64'h9000_0048, 6'd9, 55'h48_0000);
    do_req(64'h9000_0048, 1'b0);
    do_refill(1'b0);
    push_miss(64'h8000_0048, 6'd9, 55'h40_0000);
    do_req(64'h8000_0048, 1'b0);
    do_refill(1'b0);
    wait_drain("conflict");

    push_sweep();
    push_miss(64'h9000_0048, 6'd9, 55'h48_0000);
    do_req(64'h9000_0048, 1'b1);
    do_refill(1'b0);
    wait_drain("flush_with_req");

    push_miss(64'h8000_0048, 6'd9, 55'h40_0000);
    push_sweep();
    do_req(64'h8000_0048, 1'b0);
    do_refill(1'b1);
    wait_drain("flush_pending");
    push_miss(64'h8000_0048, 6'd9, 55'h40_0000);
    do_req(64'h8000_0048, 1'b0);
    do_refill(1'b0);
    wait_drain("after_pending_sweep");

    push(EV_REFILL, 64'h9000_0048);
    do_req(64'h9000_0048, 1'b0);
    wait_refill();
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef ICACHE_TAG_RST_FLUSH_EN
    push_sweep();
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_miss_refill_req", 64'(bus.refill_req_o), 64'd0);
    check("rst_miss_req_ready", 64'(bus.req_ready_o), RST_READY);
    check("rst_miss_tag_we", 64'(bus.tag_we_o), 64'd0);
    check("rst_miss_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    wait_drain("reset_mid_miss");

    push_miss(64'h9000_0048, 6'd9, 55'h48_0000);
    do_req(64'h9000_0048, 1'b0);
    do_refill(1'b0);
    push(EV_RESP, 64'd1);
    do_req(64'h9000_004F, 1'b0);
    wait_drain("post_reset");

    check("ready_during_tag_write", 64'(ready_in_sweep), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
